// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if
//   Core data-memory bus as seen by the UART transmitter window.
//   master : core side (drives strobes, address, write data; receives read data)
//   slave  : peripheral side
// Signals
//   bus_r      core read strobe
//   bus_w      byte write strobes, bit n = byte lane n
//   bus_addr   byte address
//   bus_wdata  write data
//   bus_rdata  combinational read data (0 when not selected)
interface mmio_uart_tx_if;
  logic        bus_r;
  logic [3:0]  bus_w;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    output bus_r, bus_w, bus_addr, bus_wdata,
    input  bus_rdata
  );

  modport slave (
    input  bus_r, bus_w, bus_addr, bus_wdata,
    output bus_rdata
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter. The core stores bytes into a TX FIFO
//   through a 16-byte register window; a serializer drains the FIFO onto o_tx.
//   Register window (word offset): 0 DATA (W), 1 STATUS (R/W1C overflow),
//   2 DIVISOR (R/W [15:0]), 3 CTRL (IRQ build only, otherwise reads 0).
//   Optional feature macro: MMIO_UART_TX_IRQ_EN adds CTRL[0] and o_irq.
// Ports
//   i_clk   system clock, all state on posedge
//   i_rst   synchronous active-high reset
//   bus     mmio_uart_tx_if.slave (read/write strobes, address, data)
//   o_tx    serial output, idle high
//   o_irq   (MMIO_UART_TX_IRQ_EN only) registered empty-and-idle interrupt
//
// state   | meaning
// S_IDLE  | line high, pops FIFO head when FIFO non-empty
// S_START | start bit (low), DIVISOR+1 clocks
// S_DATA  | data bits LSB first, DIVISOR+1 clocks each
// S_STOP  | stop bit (high), DIVISOR+1 clocks
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mmio_uart_tx_if.slave bus,
  output logic          o_tx
`ifdef MMIO_UART_TX_IRQ_EN
  ,
  output logic          o_irq
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic        r_ovf;
  logic [15:0] r_div;
  logic [15:0] r_baud;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_tx;

  logic        w_hit, w_wr, w_push_req, w_accept, w_pop;
  logic        w_full, w_empty, w_busy, w_baud_zero, w_ovf_set, w_ovf_clr;
  logic [1:0]  w_off;
  logic [AW:0] w_count;
  logic [7:0]  w_count8;
  logic [31:0] w_status;

  assign w_hit       = (bus.bus_addr[31:4] == BASE_ADDR[31:4]);
  assign w_off       = bus.bus_addr[3:2];
  assign w_wr        = w_hit && (|bus.bus_w);
  assign w_push_req  = w_wr && (w_off == 2'd0) && bus.bus_w[0];
  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign w_count8    = 8'(w_count);
  assign w_full      = (w_count == DEPTH_L);
  assign w_empty     = (w_count == '0);
  assign w_busy      = (r_state != S_IDLE);
  assign w_baud_zero = (r_baud == 16'd0);
  // A full FIFO still takes a byte when the serializer frees a slot this cycle.
  assign w_accept    = !w_full || w_pop;
  assign w_ovf_set   = w_push_req && !w_accept;
  assign w_ovf_clr   = w_wr && (w_off == 2'd1) && bus.bus_w[0] && bus.bus_wdata[3];
  assign w_status    = {16'h0, w_count8, 4'h0, r_ovf, w_busy, w_empty, w_full};
  assign o_tx        = r_tx;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: if (w_baud_zero) w_state_nxt = S_DATA;
      S_DATA:  if (w_baud_zero && (r_bit == 3'd7)) w_state_nxt = S_STOP;
      S_STOP:  if (w_baud_zero) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Serializer datapath. o_tx is registered from the current state so the
  // line changes one clock after the state does; durations are unaffected.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_baud  <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        S_START: r_tx <= 1'b0;
        S_DATA:  r_tx <= r_shift[0];
        default: r_tx <= 1'b1;
      endcase
      if (w_pop) begin
        r_shift <= r_mem[r_rd_ptr[AW-1:0]];
        r_baud  <= r_div;
        r_bit   <= 3'd0;
      end else if (w_busy) begin
        if (w_baud_zero) begin
          // Divisor is re-sampled at every bit boundary.
          r_baud <= r_div;
          if (r_state == S_DATA) begin
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + 3'd1;
          end
        end else begin
          r_baud <= r_baud - 16'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_req && w_accept) r_mem[r_wr_ptr[AW-1:0]] <= bus.bus_wdata[7:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
      r_div    <= DEFAULT_DIV;
    end else begin
      if (w_push_req && w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)                  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      if (w_wr && (w_off == 2'd2)) begin
        if (bus.bus_w[0]) r_div[7:0]  <= bus.bus_wdata[7:0];
        if (bus.bus_w[1]) r_div[15:8] <= bus.bus_wdata[15:8];
      end
    end
  end

`ifdef MMIO_UART_TX_IRQ_EN
  logic r_ctrl;
  logic r_irq;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ctrl <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr && (w_off == 2'd3) && bus.bus_w[0]) r_ctrl <= bus.bus_wdata[0];
      r_irq <= r_ctrl && w_empty && !w_busy;
    end
  end

  assign o_irq = r_irq;
`endif

  always_comb begin
    bus.bus_rdata = 32'h0;
    if (w_hit && bus.bus_r) begin
      case (w_off)
        2'd1: bus.bus_rdata = w_status;
        2'd2: bus.bus_rdata = {16'h0, r_div};
`ifdef MMIO_UART_TX_IRQ_EN
        2'd3: bus.bus_rdata = {31'h0, r_ctrl};
`endif
        default: bus.bus_rdata = 32'h0;
      endcase
    end
  end

  logic w_unused;
  assign w_unused = ^{bus.bus_addr[1:0], bus.bus_w[3:2], bus.bus_wdata[31:16]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
`ifdef MMIO_UART_TX_IRQ_EN
  logic irq;
`endif

  mmio_uart_tx_if bus_if();

  mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH),
    .DEFAULT_DIV(16'd433)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus_if.slave),
    .o_tx (tx)
`ifdef MMIO_UART_TX_IRQ_EN
    ,
    .o_irq(irq)
`endif
  );

  always #10 clk = ~clk;

  // Reference model: byte queue, line timing from frame start arithmetic.
  logic [7:0]  mq[$];
  logic        m_ovf;
  logic [15:0] m_div;
  logic        m_ctrl;
  logic        m_irq;
  longint      cyc;
  longint      idle_from;
  longint      f_start;
  logic [15:0] f_div;
  logic [7:0]  f_byte;
  logic        f_valid;
  logic        m_rst_edge;
  int          checks;
  int          failures;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic exp_tx();
    longint k;
    longint b;
    if (m_rst_edge || !f_valid) return 1'b1;
    k = cyc - 1 - f_start;
    if (k < 0 || k >= 10 * (longint'(f_div) + 1)) return 1'b1;
    b = k / (longint'(f_div) + 1);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return f_byte[b-1];
  endfunction

  function automatic logic m_busy();
    return cyc < idle_from;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [7:0] cnt;
    cnt = 8'(mq.size());
    return {16'h0, cnt, 4'h0, m_ovf, m_busy(), (mq.size() == 0), (mq.size() == DEPTH)};
  endfunction

  task automatic tick();
    logic        hit, wr, push_req, st_clr, pop, full, ovf_set, irq_next, rst_now;
    logic [1:0]  off;
    logic [3:0]  lanes;
    logic [31:0] wd;
    hit      = (bus_if.bus_addr[31:4] == BASE[31:4]);
    off      = bus_if.bus_addr[3:2];
    lanes    = bus_if.bus_w;
    wd       = bus_if.bus_wdata;
    wr       = hit && (|lanes);
    push_req = wr && (off == 2'd0) && lanes[0];
    st_clr   = wr && (off == 2'd1) && lanes[0] && wd[3];
    irq_next = m_ctrl && (mq.size() == 0) && !m_busy();
    rst_now  = rst;
    @(posedge clk);
    cyc++;
    if (rst_now) begin
      mq.delete();
      m_ovf      = 1'b0;
      m_div      = 16'd433;
      m_ctrl     = 1'b0;
      m_irq      = 1'b0;
      f_valid    = 1'b0;
      idle_from  = cyc;
      m_rst_edge = 1'b1;
    end else begin
      m_rst_edge = 1'b0;
      m_irq      = irq_next;
      pop        = (cyc - 1 >= idle_from) && (mq.size() > 0);
      full       = (mq.size() == DEPTH);
      ovf_set    = push_req && full && !pop;
      if (pop) begin
        f_byte    = mq.pop_front();
        f_start   = cyc;
        f_div     = m_div;
        f_valid   = 1'b1;
        idle_from = cyc + 10 * (longint'(m_div) + 1);
      end
      if (push_req && (!full || pop)) mq.push_back(wd[7:0]);
      if (ovf_set)     m_ovf = 1'b1;
      else if (st_clr) m_ovf = 1'b0;
      if (wr && off == 2'd2) begin
        if (lanes[0]) m_div[7:0]  = wd[7:0];
        if (lanes[1]) m_div[15:8] = wd[15:8];
      end
`ifdef MMIO_UART_TX_IRQ_EN
      if (wr && off == 2'd3 && lanes[0]) m_ctrl = wd[0];
`endif
    end
    #1;
    chk({31'h0, tx}, {31'h0, exp_tx()}, "tx");
`ifdef MMIO_UART_TX_IRQ_EN
    chk({31'h0, irq}, {31'h0, m_irq}, "irq");
`endif
  endtask

  task automatic wr(input logic [1:0] off, input logic [3:0] lanes, input logic [31:0] data);
    bus_if.bus_addr  = BASE + {28'h0, off, 2'b00};
    bus_if.bus_w     = lanes;
    bus_if.bus_wdata = data;
    bus_if.bus_r     = 1'b0;
    tick();
    bus_if.bus_w     = 4'h0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    bus_if.bus_addr = addr;
    bus_if.bus_r    = 1'b1;
    #1;
    chk(bus_if.bus_rdata, exp, tag);
    bus_if.bus_r    = 1'b0;
  endtask

  task automatic rd_all();
    logic [31:0] ctrl_exp;
`ifdef MMIO_UART_TX_IRQ_EN
    ctrl_exp = {31'h0, m_ctrl};
`else
    ctrl_exp = 32'h0;
`endif
    rd(BASE + 32'h0,  32'h0,             "data_rd");
    rd(BASE + 32'h4,  exp_status(),      "status");
    rd(BASE + 32'h8,  {16'h0, m_div},    "divisor");
    rd(BASE + 32'hC,  ctrl_exp,          "ctrl");
    rd(BASE + 32'h14, 32'h0,             "miss_rd");
  endtask

  initial begin
    int n;
    int d;
    int budget;
    logic [31:0] r;
    checks = 0; failures = 0;
    cyc = 0; idle_from = 0; f_valid = 1'b0; m_rst_edge = 1'b1;
    m_ovf = 1'b0; m_div = 16'd433; m_ctrl = 1'b0; m_irq = 1'b0;
    bus_if.bus_r = 1'b0; bus_if.bus_w = 4'h0;
    bus_if.bus_addr = 32'h0; bus_if.bus_wdata = 32'h0;

    // Reset values
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    rd_all();

    // DIVISOR=3, single 0x55 frame
    wr(2'd2, 4'b0011, 32'h0000_0003);
    wr(2'd0, 4'b0001, 32'hFFFF_FF55);
    repeat (10) tick();
    rd_all();
    repeat (40) tick();
    rd_all();

    // Random divisors and short bursts
    for (int i = 0; i < 6; i++) begin
      d = $urandom_range(0, 4);
      n = $urandom_range(1, 3);
      wr(2'd2, 4'b0011, d);
      for (int j = 0; j < n; j++) wr(2'd0, 4'b0001, $urandom);
      rd_all();
      repeat (n * (10 * (d + 1) + 1) + 4) tick();
      rd_all();
    end

    // Fill FIFO, overflow, clear
    wr(2'd2, 4'b0011, 32'd50);
    for (int i = 0; i < 18; i++) wr(2'd0, 4'b0001, i);
    rd_all();
    wr(2'd1, 4'b0010, 32'h0000_0008);
    rd_all();
    wr(2'd1, 4'b0001, 32'h0000_0008);
    rd_all();

    // Full FIFO, write on pop cycle
    budget = 2000;
    while (cyc < idle_from && budget > 0) begin
      tick();
      budget--;
    end
    chk(budget > 0, 1, "pop_wait_budget");
    wr(2'd0, 4'b0001, 32'h0000_00AB);
    rd_all();

    // Reset mid DATA bit 3, queued bytes must not go out
    rst = 1'b1; tick(); rst = 1'b0;
    wr(2'd2, 4'b0011, 32'd3);
    wr(2'd0, 4'b0001, $urandom);
    wr(2'd0, 4'b0001, $urandom);
    wr(2'd0, 4'b0001, $urandom);
    repeat (16) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    rd_all();
    repeat (60) tick();
    rd_all();

    // Random bus traffic
    wr(2'd2, 4'b0011, 32'd1);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: wr(2'd0, 4'($urandom_range(0, 15)), $urandom);
        4: begin
          r = $urandom & 32'hFFFF_FFF7;
          if ($urandom_range(0, 1) == 1) r = r | 32'h8;
          wr(2'd1, 4'($urandom_range(0, 15)), r);
        end
        5: if (!m_busy() && mq.size() == 0)
             wr(2'd2, 4'($urandom_range(1, 3)), $urandom_range(0, 2));
           else tick();
        6: wr(2'd3, 4'($urandom_range(0, 15)), $urandom);
        7: begin
          bus_if.bus_addr  = BASE + 32'h20;
          bus_if.bus_w     = 4'hF;
          bus_if.bus_wdata = $urandom;
          tick();
          bus_if.bus_w     = 4'h0;
        end
        default: tick();
      endcase
      if (i % 8 == 0) rd_all();
    end
    repeat (40 * DEPTH) tick();
    rd_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
